pio_in_edge: RTL
================

# pio_in_edge

Parametrised Avalon-MM input PIO with synchronisation, per-bit edge capture and a maskable level interrupt. Generalises the fixed-width polled input port: width is configurable, inputs pass through a multi-stage synchroniser, and edges are latched into a sticky register so short pulses are not lost between CPU polls. It sits between board-level inputs (limit switches, encoder and fault lines) and the Nios II data master, on the same clock as the rest of the system.

## Interface
- WIDTH, 2, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser depth (2..4).
- EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 4, stability window per bit; used only with PIO_IN_DEBOUNCE_EN (1..65535).
- clk  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave selected.
- write_n  input  1  active-low write strobe; a write takes effect when chipselect=1 and write_n=0 at a clk edge.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active high.

## Operation
- Register map, with all unused bits reading 0:
  - addr 0: DATA (RO), the conditioned input value d[WIDTH-1:0]. Writes are ignored.
  - addr 1: reads 0. Writes are ignored.
  - addr 2: IRQMASK (RW), WIDTH bits.
  - addr 3: EDGECAP (RW1C). Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- Input path: in_port passes through the synchroniser chain to give s; conditioning of s gives d; d is registered again to give d_prev.
- Edge detection, per bit i, evaluated every cycle:
  - rise_i = d_i & ~d_prev_i.
  - fall_i = ~d_i & d_prev_i.
  - The edge selected by EDGE_TYPE sets EDGECAP_i at the next edge.
- EDGECAP is sticky until cleared. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq = |(EDGECAP & IRQMASK). It is a combinational OR of flop outputs and adds no cycle of latency.
- readdata is reloaded every cycle from the address mux, independent of chipselect, as for the existing PIO.
- Reset values, all 0: readdata, irq, IRQMASK, EDGECAP, every synchroniser stage, d, d_prev, and the debounce counters.
- Because d resets to 0, an input held high through reset release produces one rising edge (EDGE_TYPE 0 or 2) once it propagates. Software clears EDGECAP after boot.
- Reset asserted mid-operation returns everything to the reset values immediately; no pending edge survives.

## Timing
- in_port changes and is stable before clk edge E0; with the debounce feature compiled out:
  - s and d update at edge E0+SYNC_STAGES-1.
  - EDGECAP sets and irq rises (if the bit is masked on) at edge E0+SYNC_STAGES.
  - readdata reflects the new DATA at edge E0+SYNC_STAGES, when address=0 was presented in the preceding cycle.
- Read latency is 1 cycle: address presented at edge N gives readdata valid after edge N+1. There are no wait states.
- Write latency:
  - IRQMASK and EDGECAP update at the write edge.
  - irq follows in the same cycle after that edge.
  - A read of the same register in the next cycle returns the new value.
- Pulses narrower than one clk period can be missed. Any pulse of at least 2 cycles (after conditioning) is captured.

## Configuration
- PIO_IN_DEBOUNCE_EN defined:
  - Each bit has a counter. d_i copies s_i only after s_i has differed from d_i for DEBOUNCE_CYCLES consecutive cycles.
  - Any return of s_i to d_i resets that bit's counter.
  - This adds DEBOUNCE_CYCLES cycles to the Timing latencies.
- PIO_IN_DEBOUNCE_EN undefined: d = s, no counters are instantiated, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset release with in_port=2'b00: readdata=0 and irq=0. Then raise in_port[0] with IRQMASK=0 -> EDGECAP reads 0x1 and irq stays 0.
- Write IRQMASK=0x3, then raise in_port[1] at E0 with SYNC_STAGES=2 -> irq=1 after E0+2, and a read of addr 3 returns 0x2. Write 0x2 to addr 3 -> irq=0 the next cycle.
- W1C of bit 0 in the same cycle a new rising edge on bit 0 reaches detection -> EDGECAP[0] stays 1 and irq stays high.
- EDGE_TYPE=2, WIDTH=8, 3-cycle pulse on in_port[7] -> EDGECAP=0x80 after the rise. Clear it; the fall sets 0x80 again.
- With PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - A 3-cycle glitch leaves DATA and EDGECAP unchanged.
  - A 6-cycle high level sets DATA bit and EDGECAP bit SYNC_STAGES+4 cycles after the change.
- Assert reset_n low while EDGECAP=0x3 and irq=1 -> irq, readdata and all registers read 0 immediately, and remain 0 after release with inputs low.

Source files
------------

// File: rtl/pio_in_edge_if.sv
// pio_in_edge_if: Avalon-MM slave register bus and interrupt line of the input PIO
interface pio_in_edge_if;
  logic [1:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic irq;
  modport master(output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave(input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_in_edge.sv
// pio_in_edge: synchronised input PIO with sticky edge capture and maskable irq; debounce via PIO_IN_DEBOUNCE_EN
module pio_in_edge #(
  parameter int WIDTH = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic reset_n,
  input logic [WIDTH-1:0] in_port,
  pio_in_edge_if.slave bus
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s, d, d_prev, irqmask, edgecap, rise, fall, edge_set, clr;
  logic wr;
  logic [31:0] rd_mux;
  logic unused_ok;
  assign s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
`ifdef PIO_IN_DEBOUNCE_EN
  logic [WIDTH-1:0][15:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      d <= '0;
    end else
      for (int i = 0; i < WIDTH; i++)
        if (s[i] == d[i]) cnt[i] <= '0;
        else if (cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          d[i] <= s[i];
        end else cnt[i] <= cnt[i] + 16'd1;
`else
  assign d = s;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) d_prev <= '0;
    else d_prev <= d;
  assign rise = d & ~d_prev;
  assign fall = ~d & d_prev;
  assign edge_set = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
  assign wr = bus.chipselect & ~bus.write_n;
  assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_ok = ^bus.writedata;
  always_comb
    rd_mux = bus.address == 2'd0 ? 32'(d) :
             bus.address == 2'd2 ? 32'(irqmask) :
             bus.address == 2'd3 ? 32'(edgecap) : 32'd0;
  // a new edge outranks a simultaneous W1C so it is never lost
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
      bus.readdata <= '0;
    end else begin
      irqmask <= (wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : irqmask;
      edgecap <= (edgecap & ~clr) | edge_set;
      bus.readdata <= rd_mux;
    end
  assign bus.irq = |(edgecap & irqmask);
endmodule
